// File: rtl/machine_pkg.sv
// Shared definitions for the control FSM and its datapath partner:
// regime codes, next-Y operation codes and default geometry.
package machine_pkg;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2,
        R3 = 2'd3
    } regime_t;

    typedef enum logic [1:0] {
        Y_HOLD     = 2'd0,
        Y_INC      = 2'd1,
        Y_DEC      = 2'd2,
        Y_XOR_PREV = 2'd3
    } y_select_t;

    localparam int DATA_W_DEFAULT   = 8;
    localparam int S_W_DEFAULT      = 3;
    localparam int S_TARGET_DEFAULT = 6;

endpackage

// File: rtl/data_path_y_bank.sv
// Y register bank: 2**S_W words, async reset, two combinational read
// ports (current index and its predecessor) and one synchronous write port.
module y_bank
    import machine_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int S_W    = S_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [S_W-1:0]    rd_addr,
    input  logic [S_W-1:0]    rd_prev_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rd_prev_data,
    input  logic              wr_en,
    input  logic [S_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** S_W;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data      = mem[rd_addr];
    assign rd_prev_data = mem[rd_prev_addr];

    // Clear every word on reset; otherwise write the addressed word when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/data_path.sv
// Datapath partner of the control FSM: index register S, the Y bank addressed
// by S, the sIs6 status flag, and the registered enumeration output stream.
module data_path
    import machine_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int S_W      = S_W_DEFAULT,
    parameter int S_TARGET = S_TARGET_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        regime,
    input  logic              active,
    input  logic              s_en,
    input  logic              s_zero,
    input  logic              s_add,
    input  logic [1:0]        s_step,
    input  logic              y_en,
    input  logic              y_store_x,
    input  logic [1:0]        y_select_next,
    output logic              sIs6,
    output logic [S_W-1:0]    s_value,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid
);

    localparam logic [S_W-1:0] S_TGT = S_W'(S_TARGET);

    logic [S_W-1:0]    s_reg;
    logic [S_W-1:0]    s_next;
    logic [S_W-1:0]    s_prev;
    logic [S_W-1:0]    step_ext;
    logic [DATA_W-1:0] y_cur;
    logic [DATA_W-1:0] y_prev;
    logic [DATA_W-1:0] y_next;
    logic              enum_fire;

    assign step_ext  = S_W'(s_step);
    assign s_prev    = s_reg - S_W'(1);
    assign sIs6      = (s_reg == S_TGT);
    assign s_value   = s_reg;
    assign enum_fire = (regime == R1) && active && s_en && !s_zero;

    // Next index: zero has priority, then add or subtract the step, wrapping naturally.
    always_comb begin
        s_next = s_reg;
        if (s_zero) begin
            s_next = '0;
        end else if (s_add) begin
            s_next = s_reg + step_ext;
        end else begin
            s_next = s_reg - step_ext;
        end
    end

    // Index register; only moves when the control word enables it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg <= '0;
        end else if (s_en) begin
            s_reg <= s_next;
        end
    end

    // New value for Y[S]: the external operand wins, otherwise the selected op on the current word.
    always_comb begin
        y_next = y_cur;
        if (y_store_x) begin
            y_next = x;
        end else begin
            case (y_select_t'(y_select_next))
                Y_HOLD:     y_next = y_cur;
                Y_INC:      y_next = y_cur + DATA_W'(1);
                Y_DEC:      y_next = y_cur - DATA_W'(1);
                Y_XOR_PREV: y_next = y_cur ^ y_prev;
                default:    y_next = y_cur;
            endcase
        end
    end

    // The bank is written and read at the pre-update S, so a same-cycle S step lands afterwards.
    y_bank #(
        .DATA_W (DATA_W),
        .S_W    (S_W)
    ) u_y_bank (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (s_reg),
        .rd_prev_addr (s_prev),
        .rd_data      (y_cur),
        .rd_prev_data (y_prev),
        .wr_en        (y_en),
        .wr_addr      (s_reg),
        .wr_data      (y_next)
    );

    // Enumeration output: capture Y[S] with a one-cycle valid pulse; y_out holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= enum_fire;
            if (enum_fire) begin
                y_out <= y_cur;
            end
        end
    end

endmodule
